snake_move_sequencer: RTL and testbench
=======================================

# snake_move_sequencer

Game-state controller for player 1 of the snake game. On every game tick it reads the buttons and computes the next head cell. It checks wall and self collision by walking the body one segment per cycle, applies apple growth, and then atomically commits a new packed `snake_data` word. The VGA renderer reads this word every pixel clock. The block sits between the button inputs and the renderer, and runs on the pixel clock.

## Interface
Parameters:
- `BOARD_W`, 40: board side in cells; cell index = 40*row + col, range 0..1599.
- `MAX_LEN`, 49: maximum body segments behind the head.
- `TICK_DIV`, 2500000: `vga_clk` cycles per game tick. Must be ≥ 64.

Ports:
- `vga_clk` in 1: pixel clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `up`, `down`, `left`, `right` in 1 each: buttons, active-low, asynchronous to the game. Double-flop synchronised inside the block.
- `start` in 1: single-cycle pulse; starts or restarts a game.
- `apple_pos` in 32: current apple cell, held stable by its producer.
- `snake_data` out 360: packed state.
  - [359:328] stage
  - [327:296] length2 = 0
  - [295:264] length1
  - [263:232] head2 = 0
  - [231:200] head1
  - [199:100] = 0
  - [99:0] direction chain; dir[k] = bits [2k+1:2k], k = 0..49.
- `apple_eaten` out 1: one-cycle pulse on the commit that grows the snake.
- `busy` out 1: high from tick acceptance through commit.

## Operation
- Stage encoding: 1 = IDLE, 2 = PLAY, 3 = OVER.
- Direction code dir[k] gives the offset from segment k to segment k+1: 00 = −40, 01 = +1, 10 = +40, 11 = −1. Segment 0 is the head.
- Heading codes use the same encoding. The new head = head + offset(heading). On commit, dir[0] ← heading XOR 2'b10, and dir[k] ← dir[k−1] for k = 1..49.
- Heading request, sampled every cycle:
  - Priority up(00) > right(01) > down(10) > left(11), using synchronised low levels.
  - A request equal to the opposite of the last committed heading is ignored.
  - The pending heading is applied at the next tick.
- FSM states: IDLE, WAIT, CALC, WALK, COMMIT, OVER.
- IDLE/OVER → on `start`: load the initial snake and go to WAIT.
  - head1 = 415, length1 = 9, dir[all] = 11, heading = 01.
  - stage = 2, published the same cycle.
- WAIT → on tick: CALC, busy = 1.
- CALC (1 cycle): form the new head and the wall flag.
  - Wall hit if heading 00 and row = 0; 01 and col = 39; 10 and row = 39; 11 and col = 0.
  - grow = (new head == `apple_pos`) and length1 < MAX_LEN.
  - Wall hit → COMMIT with the fail flag set. Otherwise → WALK with the walker at the head.
- WALK: one segment per cycle. The walker advances by offset(dir[j−1]) for j = 1..length1 and compares against the new head.
  - When not growing, the last segment (j = length1) is excluded, because the tail vacates it.
  - Any match sets fail.
  - Go to COMMIT after the final segment or on the first match.
- COMMIT (1 cycle):
  - Fail: stage ← 3; head, length and dir are unchanged; go to OVER.
  - Else: head1 ← new head, chain shifted, length1 += grow, `apple_eaten` = grow; go to WAIT.
  - busy drops on exit from COMMIT.
- Apple eaten at length1 = MAX_LEN: no growth and no `apple_eaten` pulse; the move still commits.
- `start` in WAIT/CALC/WALK: ignored. `start` in OVER: full re-initialisation.

## Timing
- Reset values: stage = 1, head1 = 415, length1 = 9, dir[all] = 11, pending heading = 01, other `snake_data` bits 0, `apple_eaten` = 0, busy = 0, tick counter = 0.
- Tick counter:
  - Runs only in stage 2. Asserts tick on count TICK_DIV−1, then wraps to 0.
  - Is cleared on `start`.
  - A tick arriving while busy is dropped, not queued.
- Latency, tick → commit: CALC 1 cycle + WALK ≤ length1 cycles + COMMIT 1 cycle, so ≤ 51 cycles. A wall failure takes 2 cycles.
- `snake_data` changes only in the COMMIT cycle or the `start` cycle, all fields in the same edge. The renderer never sees a mixed state.
- Button → pending heading: 2-cycle synchroniser plus 1 cycle.
- Reset mid-walk: immediate return to reset values; no partial commit.

## Test plan
- Reset, then `start`: `snake_data`[359:328] = 2, head1 = 415, length1 = 9, dir[0..49] = 11. After TICK_DIV+≤12 cycles, head1 = 416 and dir[0] = 11.
- Hold `up` low, then tick: head1 = 415−40 = 375, dir[0] = 10. Then press `down` (a reversal) and tick: heading stays up, head1 = 335.
- Set `apple_pos` = 416 and tick: head1 = 416, length1 = 10, `apple_eaten` high for exactly 1 cycle. Repeat growth to 49: the next apple gives no pulse and length stays 49.
- Steer right until col 39, then tick: stage = 3, head1 unchanged, busy low. Further ticks do nothing. `start` restores head1 = 415 and stage = 2.
- Self-collision: grow to length ≥ 4, then do up, left, down within 3 ticks. Stage = 3 on the down tick.
- Tail chase: a 4-cell loop with no growth, where the new head equals the current tail cell. The move commits and stage stays 2.
- Assert `reset` during WALK: all fields return to reset values within 1 cycle, and `apple_eaten` stays 0.

Source files
------------

// File: rtl/snake_move_sequencer.sv
// Player-1 snake game-state controller: each game tick steers the head, walks the body
// one segment per cycle for collisions, applies apple growth and commits snake_data atomically.
module snake_move_sequencer #(
    parameter int BOARD_W  = 40,
    parameter int MAX_LEN  = 49,
    parameter int TICK_DIV = 2500000
) (
    input  logic         vga_clk,
    input  logic         reset,
    input  logic         up,
    input  logic         down,
    input  logic         left,
    input  logic         right,
    input  logic         start,
    input  logic [31:0]  apple_pos,
    output logic [359:0] snake_data,
    output logic         apple_eaten,
    output logic         busy
);
    localparam int RW         = $clog2(BOARD_W);
    localparam int LW         = $clog2(MAX_LEN + 1);
    localparam int DIR_W      = 2 * (MAX_LEN + 1);
    localparam int PAD_W      = 200 - DIR_W;
    localparam int CW         = $clog2(TICK_DIV);
    localparam int START_HEAD = 415;
    localparam int START_LEN  = 9;

    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    localparam logic [1:0] HD_UP    = 2'b00;
    localparam logic [1:0] HD_RIGHT = 2'b01;
    localparam logic [1:0] HD_DOWN  = 2'b10;
    localparam logic [1:0] HD_LEFT  = 2'b11;

    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CALC, S_WALK, S_COMMIT, S_OVER} state_t;

    // Cells are held as row/col so wall tests and walker steps need no division.
    typedef struct packed {
        logic [RW-1:0] row;
        logic [RW-1:0] col;
    } cell_t;

    localparam cell_t START_CELL = {RW'(START_HEAD / BOARD_W), RW'(START_HEAD % BOARD_W)};

    function automatic cell_t step(input cell_t c, input logic [1:0] d);
        cell_t n;
        n = c;
        case (d)
            HD_UP:    n.row = c.row - RW'(1);
            HD_RIGHT: n.col = c.col + RW'(1);
            HD_DOWN:  n.row = c.row + RW'(1);
            default:  n.col = c.col - RW'(1);
        endcase
        return n;
    endfunction

    function automatic logic [31:0] cell_idx(input cell_t c);
        return 32'(c.row) * 32'(BOARD_W) + 32'(c.col);
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       stage_q, stage_d;
    cell_t            head_q, head_d;
    logic [LW-1:0]    len_q, len_d;
    logic [DIR_W-1:0] dir_q, dir_d;
    logic [1:0]       last_hd_q, last_hd_d;
    logic [1:0]       pend_hd_q, pend_hd_d;
    logic [1:0]       cur_hd_q, cur_hd_d;
    cell_t            new_q, new_d;
    logic             grow_q, grow_d;
    logic             fail_q, fail_d;
    cell_t            walk_q, walk_d;
    logic [LW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             eaten_q, eaten_d;
    logic [3:0]       btn_s1_q, btn_s2_q;  // {up, right, down, left}, active-low

    logic [3:0]       btn_on;
    logic             req_valid;
    logic [1:0]       req_hd;
    logic             tick;
    logic [DIR_W-1:0] dir_shift;
    cell_t            seg;
    logic [LW-1:0]    walk_last;
    logic             wall;

    assign btn_on    = ~btn_s2_q;
    assign req_valid = |btn_on;
    assign tick      = (stage_q == ST_PLAY) && (cnt_q == TICK_LAST);
    assign dir_shift = dir_q >> {idx_q, 1'b0};
    assign seg       = step(walk_q, dir_shift[1:0]);
    // Without growth the tail cell is vacated by this move, so it is not compared.
    assign walk_last = grow_q ? len_q : len_q - LW'(1);

    always_comb begin
        if (btn_on[3])      req_hd = HD_UP;
        else if (btn_on[2]) req_hd = HD_RIGHT;
        else if (btn_on[1]) req_hd = HD_DOWN;
        else                req_hd = HD_LEFT;
    end

    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        head_d    = head_q;
        len_d     = len_q;
        dir_d     = dir_q;
        last_hd_d = last_hd_q;
        pend_hd_d = pend_hd_q;
        cur_hd_d  = cur_hd_q;
        new_d     = new_q;
        grow_d    = grow_q;
        fail_d    = fail_q;
        walk_d    = walk_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        eaten_d   = 1'b0;
        wall      = 1'b0;

        if (req_valid && (req_hd != (last_hd_q ^ 2'b10))) pend_hd_d = req_hd;
        if (stage_q == ST_PLAY) cnt_d = tick ? '0 : cnt_q + CW'(1);

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    stage_d   = ST_PLAY;
                    head_d    = START_CELL;
                    len_d     = LW'(START_LEN);
                    dir_d     = {(MAX_LEN + 1){HD_LEFT}};
                    pend_hd_d = HD_RIGHT;
                    last_hd_d = HD_RIGHT;
                    cnt_d     = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tick) begin
                    cur_hd_d = pend_hd_q;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                new_d = step(head_q, cur_hd_q);
                case (cur_hd_q)
                    HD_UP:    wall = (head_q.row == '0);
                    HD_RIGHT: wall = (head_q.col == RW'(BOARD_W - 1));
                    HD_DOWN:  wall = (head_q.row == RW'(BOARD_W - 1));
                    default:  wall = (head_q.col == '0);
                endcase
                grow_d  = (cell_idx(new_d) == apple_pos) && (len_q < LW'(MAX_LEN));
                fail_d  = wall;
                walk_d  = head_q;
                idx_d   = '0;
                state_d = wall ? S_COMMIT : S_WALK;
            end
            S_WALK: begin
                if (seg == new_q) begin
                    fail_d  = 1'b1;
                    state_d = S_COMMIT;
                end else if (idx_q + LW'(1) == walk_last) begin
                    state_d = S_COMMIT;
                end else begin
                    walk_d = seg;
                    idx_d  = idx_q + LW'(1);
                end
            end
            S_COMMIT: begin
                if (fail_q) begin
                    stage_d = ST_OVER;
                    state_d = S_OVER;
                end else begin
                    head_d    = new_q;
                    dir_d     = {dir_q[DIR_W-3:0], cur_hd_q ^ 2'b10};
                    len_d     = len_q + LW'(grow_q);
                    eaten_d   = grow_q;
                    last_hd_d = cur_hd_q;
                    state_d   = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            btn_s1_q  <= '1;
            btn_s2_q  <= '1;
            state_q   <= S_IDLE;
            stage_q   <= ST_IDLE;
            head_q    <= START_CELL;
            len_q     <= LW'(START_LEN);
            dir_q     <= {(MAX_LEN + 1){HD_LEFT}};
            last_hd_q <= HD_RIGHT;
            pend_hd_q <= HD_RIGHT;
            cur_hd_q  <= HD_RIGHT;
            new_q     <= START_CELL;
            grow_q    <= 1'b0;
            fail_q    <= 1'b0;
            walk_q    <= START_CELL;
            idx_q     <= '0;
            cnt_q     <= '0;
            eaten_q   <= 1'b0;
        end else begin
            btn_s1_q  <= {up, right, down, left};
            btn_s2_q  <= btn_s1_q;
            state_q   <= state_d;
            stage_q   <= stage_d;
            head_q    <= head_d;
            len_q     <= len_d;
            dir_q     <= dir_d;
            last_hd_q <= last_hd_d;
            pend_hd_q <= pend_hd_d;
            cur_hd_q  <= cur_hd_d;
            new_q     <= new_d;
            grow_q    <= grow_d;
            fail_q    <= fail_d;
            walk_q    <= walk_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            eaten_q   <= eaten_d;
        end
    end

    assign snake_data  = {30'd0, stage_q, 32'd0, {(32 - LW){1'b0}}, len_q, 32'd0,
                          cell_idx(head_q), {PAD_W{1'b0}}, dir_q};
    assign apple_eaten = eaten_q;
    assign busy        = (state_q == S_CALC) || (state_q == S_WALK) || (state_q == S_COMMIT);

endmodule

// File: tb/tb_snake_move_sequencer.sv
// Self-checking bench for snake_move_sequencer: a cell-list snake model predicts each move,
// expectations are queued at stimulus time and compared when the DUT finishes the commit.
`timescale 1ns/1ps
module tb_snake_move_sequencer;
    localparam int          TICK_DIV = 80;
    localparam int          MAX_LEN  = 49;
    localparam logic [31:0] NO_APPLE = 32'hFFFF_FFFF;

    logic         vga_clk = 1'b0;
    logic         reset;
    logic         up, down, left, right;
    logic         start;
    logic [31:0]  apple_pos;
    logic [359:0] snake_data;
    logic         apple_eaten;
    logic         busy;

    snake_move_sequencer #(
        .BOARD_W (40),
        .MAX_LEN (MAX_LEN),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .start      (start),
        .apple_pos  (apple_pos),
        .snake_data (snake_data),
        .apple_eaten(apple_eaten),
        .busy       (busy)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic [359:0] sd;
        logic         eaten;
        logic         wall;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;

    // Reference snake: list of occupied cells, head first.
    int         m_cells[$];
    logic [1:0] m_dir[50];
    int         m_len;
    int         m_stage;
    logic [1:0] m_pend;
    logic [1:0] m_last;

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_init(input int stage);
        m_cells.delete();
        for (int k = 0; k <= 9; k++) m_cells.push_back(415 - k);
        for (int k = 0; k < 50; k++) m_dir[k] = 2'b11;
        m_len   = 9;
        m_pend  = 2'b01;
        m_last  = 2'b01;
        m_stage = stage;
    endfunction

    function automatic logic [359:0] model_sd();
        logic [99:0] d;
        for (int k = 0; k < 50; k++) d[2*k +: 2] = m_dir[k];
        return {32'(m_stage), 32'd0, 32'(m_len), 32'd0, 32'(m_cells[0]), 100'd0, d};
    endfunction

    function automatic int next_cell(input logic [1:0] h);
        case (h)
            2'b00:   return m_cells[0] - 40;
            2'b01:   return m_cells[0] + 1;
            2'b10:   return m_cells[0] + 40;
            default: return m_cells[0] - 1;
        endcase
    endfunction

    function automatic int steer();
        int r;
        int c;
        r = m_cells[0] / 40;
        c = m_cells[0] % 40;
        case (m_pend)
            2'b00:   return (r <= 5) ? 1 : 0;
            2'b01:   return (c >= 34) ? 2 : 1;
            2'b10:   return (r >= 34) ? 3 : 2;
            default: return (c <= 5) ? 0 : 3;
        endcase
    endfunction

    task automatic check_sd(input string tag, input logic [359:0] e);
        check({tag, ".stage"},   200'(snake_data[359:328]), 200'(e[359:328]));
        check({tag, ".length1"}, 200'(snake_data[295:264]), 200'(e[295:264]));
        check({tag, ".head1"},   200'(snake_data[231:200]), 200'(e[231:200]));
        check({tag, ".dir"},     200'(snake_data[99:0]),    200'(e[99:0]));
        check({tag, ".zero"},
              200'({snake_data[327:296], snake_data[263:232], snake_data[199:100]}),
              200'({e[327:296], e[263:232], e[199:100]}));
    endtask

    task automatic wait_busy(output int waited);
        waited = 0;
        while (!busy && waited < TICK_DIV + 16) begin
            @(negedge vga_clk);
            waited++;
        end
    endtask

    // press: -1 none, 0 up, 1 right, 2 down, 3 left. feed places the apple on the next cell.
    task automatic do_move(input int press, input bit feed);
        logic [3:0] btn;
        logic [1:0] h;
        int         r, c, nh, last_j, bc;
        bit         wall, grow, hit;
        exp_t       e;

        if (press >= 0 && 2'(press) != (m_last ^ 2'b10)) m_pend = 2'(press);
        h    = m_pend;
        r    = m_cells[0] / 40;
        c    = m_cells[0] % 40;
        wall = (h == 2'b00 && r == 0) || (h == 2'b01 && c == 39) ||
               (h == 2'b10 && r == 39) || (h == 2'b11 && c == 0);
        nh   = next_cell(h);
        apple_pos = (feed && !wall) ? 32'(nh) : NO_APPLE;
        btn = 4'b1111;
        if (press >= 0) btn[3 - press] = 1'b0;
        {up, right, down, left} = btn;

        grow = 1'b0;
        hit  = 1'b0;
        if (wall) begin
            m_stage = 3;
        end else begin
            grow   = feed && (m_len < MAX_LEN);
            last_j = grow ? m_len : m_len - 1;
            for (int j = 1; j <= last_j; j++) if (m_cells[j] == nh) hit = 1'b1;
            if (hit) begin
                m_stage = 3;
            end else begin
                m_cells.push_front(nh);
                if (grow) m_len++;
                else void'(m_cells.pop_back());
                for (int k = 49; k > 0; k--) m_dir[k] = m_dir[k-1];
                m_dir[0] = h ^ 2'b10;
                m_last   = h;
            end
        end
        e.sd    = model_sd();
        e.eaten = grow && !hit;
        e.wall  = wall;
        exp_q.push_back(e);

        wait_busy(bc);
        check("busy_rise", 200'(busy), 200'(1));
        {up, right, down, left} = 4'b1111;
        if (!busy) begin
            void'(exp_q.pop_front());
            return;
        end
        bc = 0;
        do begin
            @(negedge vga_clk);
            bc++;
        end while (busy && bc < 64);
        check("busy_fall", 200'(busy), 200'(0));

        e = exp_q.pop_front();
        check_sd("move", e.sd);
        check("apple_eaten", 200'(apple_eaten), 200'(e.eaten));
        if (e.wall) check("wall_latency", 200'(bc), 200'(2));
        else        check("latency_le_51", 200'(bc <= 51), 200'(1));
        if (e.eaten) begin
            @(negedge vga_clk);
            check("eaten_pulse_end", 200'(apple_eaten), 200'(0));
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge vga_clk);
        start = 1'b0;
        model_init(2);
        check_sd("start", model_sd());
        check("start.busy", 200'(busy), 200'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  seq[16] = '{0, 3, 3, 3, 3, 2, 1, 1, 1, 1, 0, 3, 3, 3, 3, 2};
        int  waited;
        bit  seen;

        reset = 1'b1;
        start = 1'b0;
        {up, right, down, left} = 4'b1111;
        apple_pos = NO_APPLE;
        model_init(1);
        repeat (3) @(negedge vga_clk);
        check_sd("reset", model_sd());
        check("reset.busy", 200'(busy), 200'(0));
        check("reset.eaten", 200'(apple_eaten), 200'(0));
        reset = 1'b0;
        @(negedge vga_clk);

        // Straight move, turn up, then an ignored reversal.
        do_start();
        do_move(-1, 0);
        do_move(0, 0);
        do_move(2, 0);

        // Grow to the maximum, then one more apple at full length.
        for (int n = 0; n < 60 && m_len < MAX_LEN; n++) do_move(steer(), 1'b1);
        do_move(steer(), 1'b1);

        // Drive right into the wall, then ticks in OVER must do nothing.
        for (int n = 0; n < 45 && m_stage == 2; n++) do_move(1, 0);
        seen = 1'b0;
        repeat (2 * TICK_DIV) begin
            @(negedge vga_clk);
            seen |= busy;
        end
        check("over.no_busy", 200'(seen), 200'(0));
        check_sd("over.frozen", model_sd());

        // Restart and run into the body: up, left, down.
        do_start();
        do_move(0, 0);
        do_move(3, 0);
        do_move(2, 0);

        // Restart and chase the tail around a closed loop.
        do_start();
        foreach (seq[i]) do_move(seq[i], 1'b0);

        // Reset in the middle of a growing walk.
        apple_pos = 32'(next_cell(m_pend));
        wait_busy(waited);
        check("rst.busy_rise", 200'(busy), 200'(1));
        repeat (2) @(negedge vga_clk);
        reset = 1'b1;
        #1;
        model_init(1);
        check_sd("midwalk_reset", model_sd());
        check("midwalk_reset.busy", 200'(busy), 200'(0));
        check("midwalk_reset.eaten", 200'(apple_eaten), 200'(0));
        seen = 1'b0;
        repeat (12) begin
            @(negedge vga_clk);
            seen |= apple_eaten;
        end
        check("midwalk_reset.eaten_low", 200'(seen), 200'(0));
        reset = 1'b0;
        repeat (2) @(negedge vga_clk);
        check_sd("after_reset", model_sd());
        check("after_reset.busy", 200'(busy), 200'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
